// File: rtl/mos6502s_pkg.sv
// Shared definitions for the 6502 stack-transfer engine:
// command encodings, sequencer states and reset defaults.
package mos6502s_pkg;

    localparam logic [1:0] CMD_PUSH_PC   = 2'd0;
    localparam logic [1:0] CMD_PUSH_PC_P = 2'd1;
    localparam logic [1:0] CMD_PULL_PC   = 2'd2;
    localparam logic [1:0] CMD_PULL_P_PC = 2'd3;

    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;
    localparam logic [7:0] SP_RESET_DEFAULT   = 8'hFD;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH_HI,
        S_PUSH_LO,
        S_PUSH_P,
        S_PULL_P,
        S_PULL_LO,
        S_PULL_HI,
        S_PULL_WAIT,
        S_DONE
    } stk_state_e;

    function automatic logic is_pull(input logic [1:0] c);
        return c[1];
    endfunction

endpackage

// File: rtl/mos6502s_stack_pointer.sv
// 8-bit stack pointer register with load/inc/dec and a look-ahead
// sp+1 used as the pull address. Arithmetic wraps modulo 256.
module mos6502s_stack_pointer
    import mos6502s_pkg::*;
#(
    parameter logic [7:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] sp,
    output logic [7:0] sp_plus1
);

    logic [7:0] sp_q;
    logic [7:0] sp_d;

    always_comb begin
        sp_d = sp_q;
        if (load) begin
            sp_d = din;
        end else if (dec) begin
            sp_d = sp_q - 8'd1;
        end else if (inc) begin
            sp_d = sp_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= SP_RESET;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp       = sp_q;
    assign sp_plus1 = sp_q + 8'd1;

endmodule

// File: rtl/mos6502s_stack_sequencer.sv
// Stack-transfer engine: pushes PC/P to page 1 for JSR/interrupts and
// pulls them back for RTS/RTI, one bus byte per cycle.
module mos6502s_stack_sequencer
    import mos6502s_pkg::*;
#(
    parameter logic [7:0] SP_RESET   = SP_RESET_DEFAULT,
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd,
    output logic        cmd_ready,
    input  logic [15:0] pc_in,
    input  logic [7:0]  p_in,
    input  logic        sp_load,
    input  logic [7:0]  sp_in,
    output logic [7:0]  sp,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        pc_load,
    output logic        pc_inc,
    output logic [15:0] addr_out,
    output logic        p_load,
    output logic [7:0]  p_out,
    output logic        busy,
    output logic        done
);

    stk_state_e  state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  p_push_q, p_push_d;
    logic [7:0]  p_out_q, p_out_d;

    logic       sp_ld, sp_inc, sp_dec;
    logic [7:0] sp_plus1;
    logic       idle, accept, pushing, pulling;

    assign idle    = (state_q == S_IDLE);
    assign accept  = idle && !sp_load && cmd_valid;
    assign pushing = (state_q == S_PUSH_HI) || (state_q == S_PUSH_LO)
                  || (state_q == S_PUSH_P);
    assign pulling = (state_q == S_PULL_P) || (state_q == S_PULL_LO)
                  || (state_q == S_PULL_HI);

    assign sp_ld  = idle && sp_load;
    assign sp_dec = pushing;
    assign sp_inc = pulling;

    mos6502s_stack_pointer #(
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk      (clk),
        .rst      (rst),
        .load     (sp_ld),
        .din      (sp_in),
        .inc      (sp_inc),
        .dec      (sp_dec),
        .sp       (sp),
        .sp_plus1 (sp_plus1)
    );

    // pc_q holds the PC to push, and is refilled byte-wise on pulls.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        pc_d     = pc_q;
        p_push_d = p_push_q;
        p_out_d  = p_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cmd_d    = cmd;
                    pc_d     = pc_in;
                    p_push_d = p_in;
                    unique case (cmd)
                        CMD_PULL_P_PC: state_d = S_PULL_P;
                        CMD_PULL_PC:   state_d = S_PULL_LO;
                        default:       state_d = S_PUSH_HI;
                    endcase
                end
            end
            S_PUSH_HI: state_d = S_PUSH_LO;
            S_PUSH_LO: begin
                state_d = (cmd_q == CMD_PUSH_PC_P) ? S_PUSH_P : S_DONE;
            end
            S_PUSH_P:  state_d = S_DONE;
            S_PULL_P:  state_d = S_PULL_LO;
            S_PULL_LO: begin
                if (cmd_q == CMD_PULL_P_PC) begin
                    p_out_d = mem_rdata;
                end
                state_d = S_PULL_HI;
            end
            S_PULL_HI: begin
                pc_d[7:0] = mem_rdata;
                state_d   = S_PULL_WAIT;
            end
            S_PULL_WAIT: begin
                pc_d[15:8] = mem_rdata;
                state_d    = S_DONE;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= CMD_PUSH_PC;
            pc_q     <= 16'h0000;
            p_push_q <= 8'h00;
            p_out_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            pc_q     <= pc_d;
            p_push_q <= p_push_d;
            p_out_q  <= p_out_d;
        end
    end

    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        addr_out  = 16'h0000;
        p_load    = 1'b0;
        done      = 1'b0;
        if (pushing) begin
            mem_we   = 1'b1;
            mem_addr = {STACK_PAGE, sp};
        end
        if (pulling) begin
            mem_re   = 1'b1;
            mem_addr = {STACK_PAGE, sp_plus1};
        end
        unique case (state_q)
            S_PUSH_HI: mem_wdata = pc_q[15:8];
            S_PUSH_LO: mem_wdata = pc_q[7:0];
            S_PUSH_P:  mem_wdata = p_push_q;
            S_DONE: begin
                done = 1'b1;
                if (is_pull(cmd_q)) begin
                    pc_load  = 1'b1;
                    addr_out = pc_q;
                    pc_inc   = (cmd_q == CMD_PULL_PC);
                    p_load   = (cmd_q == CMD_PULL_P_PC);
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = idle && !sp_load;
    assign busy      = !idle;
    assign p_out     = p_out_q;

endmodule

// File: doc/mos6502s_stack_sequencer.md
# mos6502s_stack_sequencer

Stack-transfer engine for the 6502 core: saves the program counter (and status) to page 1 on JSR/interrupt entry, and restores it on RTS/RTI. The restore path drives the program counter's `load`/`inc`/`addr_in` controls. The block owns the stack pointer and sequences single-byte accesses on the shared memory bus.

## Interface
Parameters:
- `SP_RESET`, 8'hFD: stack pointer value after reset.
- `STACK_PAGE`, 8'h01: high address byte of every stack access.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd` in 2: 0 PUSH_PC (JSR), 1 PUSH_PC_P (interrupt), 2 PULL_PC (RTS), 3 PULL_P_PC (RTI).
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `pc_in` in 16: PC to push, sampled at accept.
- `p_in` in 8: status to push, sampled at accept.
- `sp_load` in 1, `sp_in` in 8: TXS write.
- `sp` out 8: current stack pointer (TSX source).
- `mem_addr` out 16, `mem_wdata` out 8, `mem_we` out 1, `mem_re` out 1: memory request.
- `mem_rdata` in 8: read data, valid the cycle after `mem_re`.
- `pc_load` out 1, `pc_inc` out 1, `addr_out` out 16: to program counter `load`/`inc`/`addr_in`.
- `p_load` out 1, `p_out` out 8: restored status.
- `busy` out 1, `done` out 1: `done` is a one-cycle completion pulse.

## Operation
- FSM states: IDLE, PUSH_HI, PUSH_LO, PUSH_P, PULL_P, PULL_LO, PULL_HI, PULL_WAIT, DONE.
- `cmd_ready = (state==IDLE) & !sp_load`.
  - `sp_load` in IDLE has priority: it loads SP and blocks acceptance that cycle.
  - `sp_load` outside IDLE is ignored.
- Accept in IDLE latches `pc_in` and `p_in`.
  - cmd 0/1 go to PUSH_HI.
  - cmd 3 goes to PULL_P.
  - cmd 2 goes to PULL_LO.
- Push state (one byte per cycle):
  - `mem_we=1`, `mem_addr={STACK_PAGE,sp}`.
  - `sp <= sp-1`.
  - Order: PC[15:8], then PC[7:0], then P (cmd 1 only).
  - After the last push, go to DONE.
- Pull state (PULL_P, PULL_LO, PULL_HI):
  - `mem_re=1`, `mem_addr={STACK_PAGE,sp+1}`.
  - `sp <= sp+1`.
- Read data is captured the following cycle. PULL_LO captures P, PULL_HI captures lo, PULL_WAIT captures hi.
- After PULL_HI, go to PULL_WAIT (no bus access), then DONE.
- DONE:
  - `done=1`; return to IDLE.
  - For pull commands, `pc_load=1` and `addr_out={hi,lo}`.
  - `pc_inc=1` for PULL_PC (RTS return +1); `pc_inc=0` for PULL_P_PC.
  - `p_load=1` and `p_out=captured P` for PULL_P_PC only.
- Outputs are combinational from state and registers.
  - In IDLE, all strobes are 0 and `mem_addr`/`mem_wdata`/`addr_out` are 0.
  - `p_out` holds its last captured value.
- SP arithmetic is 8-bit modulo 256: 00−1=FF and FF+1=00. The address high byte is never affected.
- `busy = (state != IDLE)`.

## Timing
- Reset values: state IDLE, `sp=SP_RESET`, `p_out=0`, all strobes/`busy`/`done` 0.
- Reset mid-operation aborts immediately: no further bus access and no `done`.
- Cycle 0 is the accept cycle.
- PUSH_PC: writes in cycles 1–2, `done` in cycle 3, accept possible again in cycle 4.
- PUSH_PC_P: writes in cycles 1–3, `done` in cycle 4.
- PULL_PC: reads in cycles 1–2, wait in cycle 3, `done`/`pc_load` in cycle 4.
- PULL_P_PC: reads in cycles 1–3, wait in cycle 4, `done`/`pc_load`/`p_load` in cycle 5.
- `cmd_valid` is don't-care while busy; no command queueing.

## Structure
- Shared package `mos6502s_pkg`: cmd encoding constants, FSM state enum, `STACK_PAGE_DEFAULT`, `SP_RESET_DEFAULT`.
- Sub-module `mos6502s_stack_pointer`: 8-bit register with load, inc and dec, plus a `sp_plus1` output; synchronous reset to `SP_RESET`.

## Test plan
- Reset, then PUSH_PC with `pc_in`=16'h1234 → cycle 1 writes 12 @0x01FD, cycle 2 writes 34 @0x01FC, `done` in cycle 3, `sp`=FB.
- PUSH_PC_P with `sp`=01, PC=ABCD, P=0x24 → writes AB@0101, CD@0100, 24@01FF; final `sp`=FE (wrap).
- Memory preloaded 0x01FC=34, 0x01FD=12, `sp`=FB; PULL_PC → `done` in cycle 4 with `pc_load=1`, `pc_inc=1`, `addr_out`=1234, `sp`=FD.
- Memory 0x0100=A5, 0x0101=00, 0x0102=80, `sp`=FF; PULL_P_PC → reads at 0100/0101/0102, `p_out`=A5, `addr_out`=8000, `pc_inc=0`, `sp`=02.
- `sp_load` with `sp_in`=0x40 and `cmd_valid` in the same IDLE cycle → `sp`=40, command accepted next cycle, pushes start at 0x0140; `sp_load` while busy → `sp` is unchanged by it.
- `rst` asserted in cycle 2 of PULL_P_PC → next cycle IDLE, `sp`=FD, no `done`/`pc_load`/`p_load`, all strobes low.
